ps2_transmit: RTL and testbench

PS2_TRANSMIT -- requirements
Module: ps2_transmit

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_sync.sv | 28 ++
 rtl/ps2_transmit.sv | 151 +++++++++++++++
 tb/tb_ps2_transmit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and defaults for the PS/2 host-to-device transmitter.
// The state encoding and timing defaults live here so all files agree.
package ps2_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_SHIFT,
    S_ACK,
    S_WAITIDLE,
    S_DONE,
    S_ERROR
  } state_t;

  localparam int INHIBIT_DEF = 5000;
  localparam int TIMEOUT_DEF = 750000;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for a raw PS/2 line with a falling-edge strobe.
// Everything resets high, the idle level of an open-drain PS/2 line.
module ps2_sync (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta  <= 1'b1;
      level <= 1'b1;
      prev  <= 1'b1;
    end else begin
      meta  <= line;
      level <= meta;
      prev  <= level;
    end
  end

  assign fall = prev & ~level;

endmodule

// File: rtl/ps2_transmit.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send,
// shift data/parity/stop on device clock falls, then check the ACK.
module ps2_transmit
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic       clock50,
  input  logic       reset,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  state_t state;
  state_t next;

  logic          clk_s;
  logic          clk_fall;
  logic          dat_m;
  logic          dat_s;
  logic [IW-1:0] inh_cnt;
  logic [TW-1:0] to_cnt;
  logic [8:0]    sh;
  logic [3:0]    bcnt;
  logic          bit_low;
  logic          timed_out;
  logic          inh_last;
  logic          to_run;
  logic          shift_en;

  ps2_sync u_clk_sync (
    .clk   (clock50),
    .rst   (reset),
    .line  (ps2_clk_i),
    .level (clk_s),
    .fall  (clk_fall)
  );

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      dat_m <= 1'b1;
      dat_s <= 1'b1;
    end else begin
      dat_m <= ps2_dat_i;
      dat_s <= dat_m;
    end
  end

  assign inh_last  = (inh_cnt == INH_LAST);
  assign timed_out = (to_cnt == TO_LAST);

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE: begin
        if (tx_start) next = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (inh_last) next = S_REQUEST;
      end
      S_REQUEST: begin
        if (timed_out)     next = S_ERROR;
        else if (clk_fall) next = S_SHIFT;
      end
      S_SHIFT: begin
        if (timed_out)
          next = S_ERROR;
        else if (clk_fall && bcnt == 4'd9)
          next = S_ACK;
      end
      S_ACK: begin
        if (timed_out)     next = S_ERROR;
        else if (clk_fall) next = dat_s ? S_ERROR : S_WAITIDLE;
      end
      S_WAITIDLE: begin
        if (timed_out)          next = S_ERROR;
        else if (clk_s && dat_s) next = S_DONE;
      end
      S_DONE:  next = S_IDLE;
      S_ERROR: next = S_IDLE;
      default: next = S_IDLE;
    endcase
  end

  always_comb begin
    ps2_clk_oe = 1'b0;
    ps2_dat_oe = 1'b0;
    tx_busy    = (state != S_IDLE);
    tx_done    = (state == S_DONE);
    tx_error   = (state == S_ERROR);
    unique case (1'b1)
      (state == S_INHIBIT): begin
        ps2_clk_oe = 1'b1;
        ps2_dat_oe = inh_last;
      end
      (state == S_REQUEST): ps2_dat_oe = 1'b1;
      (state == S_SHIFT):   ps2_dat_oe = bit_low;
      default: ;
    endcase
  end

  // The watchdog spans the whole device-clocked part of the frame.
  assign to_run = (state == S_REQUEST) || (state == S_SHIFT) ||
                  (state == S_ACK) || (state == S_WAITIDLE);

  // Edge 1 arrives in REQUEST; edges 2..9 in SHIFT; edge 10 releases.
  assign shift_en = clk_fall &&
                    ((state == S_REQUEST) ||
                     (state == S_SHIFT && bcnt != 4'd9));

  always_ff @(posedge clock50 or posedge reset) begin
    if (reset) begin
      inh_cnt <= '0;
      to_cnt  <= '0;
      sh      <= '0;
      bcnt    <= '0;
      bit_low <= 1'b0;
    end else begin
      inh_cnt <= (state == S_INHIBIT) ? inh_cnt + 1'b1 : '0;
      to_cnt  <= to_run ? to_cnt + 1'b1 : '0;
      if (state == S_IDLE && tx_start) begin
        sh      <= {odd_parity(tx_data), tx_data};
        bcnt    <= '0;
        bit_low <= 1'b0;
      end else if (shift_en) begin
        bit_low <= ~sh[0];
        sh      <= {1'b0, sh[8:1]};
        bcnt    <= bcnt + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_transmit.sv
// Bench for ps2_transmit: a PS/2 device model on an open-drain bus,
// with expected outcomes queued at stimulus time and checked on pulses.
module tb_ps2_transmit;

  localparam int INH  = 5000;
  localparam int TO   = 3000;
  localparam int HALF = 20;

  logic       clock50 = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk_i;
  logic       ps2_dat_i;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;

  assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

  typedef struct packed {
    logic        is_err;
    logic        chk_frame;
    logic [10:0] frame;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [10:0] captured = '0;
  int          checks = 0;
  int          errors = 0;

  ps2_transmit #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock50    (clock50),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_dat_i  (ps2_dat_i),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_dat_oe (ps2_dat_oe),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  always #10 clock50 = ~clock50;

  function automatic void chk(string name, logic [31:0] got,
                              logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endfunction

  // Frame on the wire, bit 0 first: start, d0..d7, parity, stop.
  function automatic void push(logic is_err, logic chk_frame,
                               logic [7:0] d, logic par);
    exp_t e;
    e.is_err    = is_err;
    e.chk_frame = chk_frame;
    e.frame     = {1'b1, par, d, 1'b0};
    exp_q.push_back(e);
  endfunction

  task automatic start(input logic [7:0] d);
    @(negedge clock50);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clock50);
    tx_start = 1'b0;
  endtask

  task automatic device(input int n_edges, input logic ack);
    int          n;
    logic [10:0] f;
    f = '0;
    n = 0;
    while (!ps2_clk_oe && n < 1000) begin
      @(negedge clock50);
      n++;
    end
    chk("inhibit_seen", ps2_clk_oe, 1);
    if (!ps2_clk_oe) return;
    n = 0;
    while (ps2_clk_oe && n < 4 * INH) begin
      @(negedge clock50);
      n++;
    end
    chk("inhibit_len", n, INH);
    chk("start_bit_drive", ps2_dat_oe, 1);
    if (n_edges == 0) return;
    repeat (10) @(negedge clock50);
    f[0] = ps2_dat_i;
    for (int e = 1; e <= n_edges; e++) begin
      if (e == 11 && ack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clock50);
      if (e <= 10) f[e] = ps2_dat_i;
      if (e == 10) captured = f;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clock50);
      dev_dat = 1'b1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (tx_busy && n < 2 * TO) begin
      @(negedge clock50);
      n++;
    end
    chk("busy_clear", tx_busy, 0);
    repeat (5) @(negedge clock50);
  endtask

  always @(negedge clock50) begin
    if (!reset) begin
      if (tx_done && tx_error) chk("done_and_error", 1, 0);
      if (tx_done || tx_error) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {tx_done, tx_error}, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("pulse_kind", {tx_done, tx_error},
              mon_e.is_err ? 2'b01 : 2'b10);
          if (mon_e.chk_frame)
            chk("wire_frame", captured, mon_e.frame);
          chk("lines_released", {ps2_clk_oe, ps2_dat_oe}, 0);
          chk("busy_at_pulse", tx_busy, 1);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not end, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clock50);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_dat_oe", ps2_dat_oe, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_pulses", {tx_done, tx_error}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock50);

    // 0xED has six ones, so the odd parity bit is 1.
    push(1'b0, 1'b1, 8'hED, 1'b1);
    start(8'hED);
    device(11, 1'b1);
    wait_idle();

    push(1'b0, 1'b1, 8'h00, 1'b1);
    start(8'h00);
    device(11, 1'b1);
    wait_idle();

    // Device leaves data high on the ACK edge.
    push(1'b1, 1'b1, 8'h3C, 1'b1);
    start(8'h3C);
    device(11, 1'b0);
    wait_idle();
    chk("nack_released", {ps2_clk_oe, ps2_dat_oe}, 0);

    // Device never clocks: error exactly TO cycles after REQUEST entry.
    push(1'b1, 1'b0, 8'h12, 1'b1);
    start(8'h12);
    device(0, 1'b1);
    n = 0;
    while (!tx_error && n < TO + 100) begin
      @(negedge clock50);
      n++;
    end
    chk("timeout_len", n, TO);
    wait_idle();

    // Reset after edge 4: lines drop at once, no pulse follows.
    start(8'hA5);
    device(4, 1'b1);
    @(negedge clock50);
    #1 reset = 1'b1;
    #1;
    chk("midrst_oe", {ps2_clk_oe, ps2_dat_oe}, 0);
    chk("midrst_busy", tx_busy, 0);
    @(negedge clock50);
    reset = 1'b0;
    repeat (50) @(negedge clock50);
    chk("post_rst_idle", {tx_busy, ps2_clk_oe}, 0);

    // 0xF4 has five ones: parity 0.
    push(1'b0, 1'b1, 8'hF4, 1'b0);
    start(8'hF4);
    device(11, 1'b1);
    wait_idle();

    // A second start and data change mid-frame must not disturb 0xED.
    push(1'b0, 1'b1, 8'hED, 1'b1);
    start(8'hED);
    fork
      device(11, 1'b1);
      begin
        repeat (INH + 120) @(negedge clock50);
        tx_data  = 8'h55;
        tx_start = 1'b1;
        @(negedge clock50);
        tx_start = 1'b0;
        tx_data  = 8'hFF;
      end
    join
    wait_idle();
    repeat (100) @(negedge clock50);
    chk("no_second_frame", {tx_busy, ps2_clk_oe}, 0);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
